// File: rtl/uart_buf_pkg.sv
// Shared constants for the buffered UART transmit path: FSM state codes and
// the timeout-counter width helper.
package uart_buf_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int tmo_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is always visible
// on rdata_o; full/empty are registered from the next-state count.
module sync_fifo_fwft #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       push_data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              full_q, empty_q;
  logic              wr_en, rd_en;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign wr_en = push_i && !full_q;
  assign rd_en = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit buffer in front of the UART tx core: FIFO plus one-start-per-word
// handshake FSM. Define UART_TXBUF_STATUS_EN to add the level/overflow ports.
module uart_tx_fifo_ctrl
  import uart_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int BUSY_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dataReady,
  input  logic [DATA_W-1:0]       data,
  output logic                    bufFull,
  output logic                    bufEmpty,
  input  logic                    txBusy,
  output logic                    txStart,
  output logic [DATA_W-1:0]       txData,
`ifdef UART_TXBUF_STATUS_EN
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
`endif
  output logic [1:0]              dbg_state
);

  localparam int TW = tmo_w(BUSY_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_WAIT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] txdata_q, txdata_d;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (dataReady),
    .push_data_i (data),
    .pop_i       (pop),
    .rdata_o     (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    start_d  = 1'b0;
    txdata_d = txdata_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !txBusy) begin
          pop      = 1'b1;
          txdata_d = head;
          start_d  = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        tmr_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      // A core that never reports busy is assumed to have taken the word.
      ST_WAIT_BUSY: begin
        if (txBusy)                 state_d = ST_WAIT_DONE;
        else if (tmr_q == TMO_LAST) state_d = ST_IDLE;
        else                        tmr_d   = tmr_q + TMO_ONE;
      end
      ST_WAIT_DONE: begin
        if (!txBusy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      start_q  <= 1'b0;
      txdata_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      start_q  <= start_d;
      txdata_q <= txdata_d;
    end
  end

  assign bufFull   = fifo_full;
  assign bufEmpty  = fifo_empty;
  assign txStart   = start_q;
  assign txData    = txdata_q;
  assign dbg_state = state_q;

`ifdef UART_TXBUF_STATUS_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (!rst)                       overflow_q <= 1'b0;
    else if (dataReady && fifo_full) overflow_q <= 1'b1;
  end

  assign level    = fifo_count;
  assign overflow = overflow_q;
`else
  logic [$clog2(DEPTH):0] fifo_count_unused;
  assign fifo_count_unused = fifo_count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: queue reference model of accepted words, a
// simple tx-core emulation and directed scenarios. Honours UART_TXBUF_STATUS_EN.
module tb_uart_tx_fifo_ctrl;
  import uart_buf_pkg::*;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 64;
  localparam int BUSY_WAIT = 4;
  localparam int LVL_W     = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b0;
  logic              dataReady = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              txBusy = 1'b0;
  logic              bufFull, bufEmpty, txStart;
  logic [DATA_W-1:0] txData;
  logic [1:0]        dbg_state;
`ifdef UART_TXBUF_STATUS_EN
  logic [LVL_W-1:0]  level;
  logic              overflow;
`endif

  uart_tx_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .dataReady (dataReady),
    .data      (data),
    .bufFull   (bufFull),
    .bufEmpty  (bufEmpty),
    .txBusy    (txBusy),
    .txStart   (txStart),
    .txData    (txData),
`ifdef UART_TXBUF_STATUS_EN
    .level     (level),
    .overflow  (overflow),
`endif
    .dbg_state (dbg_state)
  );

  // scoreboard / reference model state
  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ovf = 1'b0;
  logic [DATA_W-1:0] exp_txdata = '0;
  logic allowed = 1'b1;
  logic saw_busy = 1'b0;
  int   wait_cnt = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   n_accepted = 0;
  int   last_start_cyc = 0;
  int   prev_start_cyc = 0;
  logic core_auto = 1'b0;
  int   core_dly = 0;
  int   core_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the inputs as driven, then check outputs.
  task automatic tick();
    logic              p_rst, p_dr, p_busy;
    logic [DATA_W-1:0] p_data;
    p_rst  = rst;
    p_dr   = dataReady;
    p_busy = txBusy;
    p_data = data;
    if (!p_rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      allowed = 1'b1;
    end else begin
      if (!allowed) begin
        if (p_busy) saw_busy = 1'b1;
        else if (saw_busy) allowed = 1'b1;
        else begin
          wait_cnt++;
          if (wait_cnt >= BUSY_WAIT) allowed = 1'b1;
        end
      end
      if (p_dr) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(p_data);
          n_accepted++;
        end else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!p_rst) begin
      exp_txdata = '0;
      chk("rst_txStart", txStart, 0);
      chk("rst_txData", txData, exp_txdata);
    end else if (txStart) begin
      n_starts++;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
      chk("start_rearm", allowed, 1);
      chk("start_while_busy", p_busy, 0);
      if (exp_q.size() == 0) chk("start_from_empty", txStart, 0);
      else begin
        exp_txdata = exp_q.pop_front();
        chk("txData_order", txData, exp_txdata);
      end
      allowed = 1'b0;
      saw_busy = 1'b0;
      wait_cnt = 0;
    end else begin
      chk("txData_hold", txData, exp_txdata);
    end
    chk("bufEmpty", bufEmpty, exp_q.size() == 0);
    chk("bufFull", bufFull, exp_q.size() == DEPTH);
`ifdef UART_TXBUF_STATUS_EN
    chk("level", level, exp_q.size());
    chk("overflow", overflow, exp_ovf);
`endif
    // tx core emulation: busy rises 1..3 cycles after a start, lasts 2..8
    if (core_auto) begin
      if (txStart) begin
        core_dly = $urandom_range(1, 3);
        core_len = $urandom_range(2, 8);
      end else if (core_dly > 0) begin
        core_dly--;
        if (core_dly == 0) txBusy = 1'b1;
      end else if (txBusy) begin
        core_len--;
        if (core_len == 0) txBusy = 1'b0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_word(input logic [DATA_W-1:0] w);
    dataReady = 1'b1;
    data = w;
    tick();
    dataReady = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    dataReady = 1'b0;
    while ((exp_q.size() != 0) && (budget < 4000)) begin
      tick();
      budget++;
    end
    chk(tag, exp_q.size(), 0);
    ticks(30);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int pushed;

    // 1. reset with dataReady high stores nothing
    rst = 1'b0;
    dataReady = 1'b1;
    data = 8'h5A;
    ticks(3);
    chk("reset_bufEmpty", bufEmpty, 1);
    chk("reset_bufFull", bufFull, 0);
    chk("reset_txStart", txStart, 0);
    chk("reset_txData", txData, 0);
    chk("reset_state", dbg_state, ST_IDLE);
`ifdef UART_TXBUF_STATUS_EN
    chk("reset_level", level, 0);
    chk("reset_overflow", overflow, 0);
`endif
    dataReady = 1'b0;
    rst = 1'b1;
    ticks(5);
    chk("reset_no_word", n_starts, 0);

    // 2. single word: start one cycle after acceptance, held off by busy
    write_word(8'hA5);
    chk("latency_not_early", txStart, 0);
    tick();
    chk("latency_start", txStart, 1);
    chk("latency_data", txData, 8'hA5);
    write_word(8'h3C);
    txBusy = 1'b1;
    base = n_starts;
    ticks(10);
    chk("busy_holds_second", n_starts - base, 0);
    txBusy = 1'b0;
    tick();
    chk("busy_fall_not_early", txStart, 0);
    tick();
    chk("busy_fall_start", txStart, 1);
    chk("busy_fall_data", txData, 8'h3C);
    core_auto = 1'b1;
    ticks(30);

    // 3. fill to full while busy, drop 0xFF, then drain in order
    core_auto = 1'b0;
    txBusy = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(DATA_W'($urandom_range(0, 8'hFE)));
    chk("full_after_depth", bufFull, 1);
    write_word(8'hFF);
    chk("full_after_drop", bufFull, 1);
`ifdef UART_TXBUF_STATUS_EN
    chk("overflow_set", overflow, 1);
`endif
    base = n_starts;
    txBusy = 1'b0;
    core_auto = 1'b1;
    drain("full_drain");
    chk("full_drain_starts", n_starts - base, DEPTH);

    // 4. push and pop on the same edge at occupancy 5
    core_auto = 1'b0;
    txBusy = 1'b1;
    for (int i = 0; i < 5; i++) write_word(DATA_W'($urandom));
    txBusy = 1'b0;
    core_auto = 1'b1;
    dataReady = 1'b1;
    data = DATA_W'($urandom);
    tick();
    dataReady = 1'b0;
    chk("pushpop_start", txStart, 1);
`ifdef UART_TXBUF_STATUS_EN
    chk("pushpop_level", level, 5);
`endif
    // random traffic through at least three pointer wraps
    base = n_starts;
    pushed = n_accepted;
    while ((n_accepted - pushed < 3 * DEPTH) && (cyc < 60000)) begin
      dataReady = 1'($urandom_range(0, 1));
      data = DATA_W'($urandom);
      tick();
    end
    drain("wrap_drain");
    chk("wrap_count", (n_accepted - pushed) >= 3 * DEPTH, 1);

    // 5. busy never rises: timeout rearms after BUSY_WAIT waiting cycles
    core_auto = 1'b0;
    txBusy = 1'b0;
    ticks(20);
    base = n_starts;
    write_word(8'hB1);
    write_word(8'hB2);
    for (int i = 0; i < 40 && n_starts < base + 2; i++) tick();
    chk("timeout_starts", n_starts - base, 2);
    chk("timeout_gap", last_start_cyc - prev_start_cyc, BUSY_WAIT + 2);
    chk("timeout_last_data", txData, 8'hB2);
    ticks(20);

    // 6. reset while waiting for the core with ten words queued
    write_word(8'hC0);
    tick();
    chk("wd_start", txStart, 1);
    txBusy = 1'b1;
    ticks(2);
    for (int i = 0; i < 10; i++) write_word(DATA_W'($urandom));
    chk("wd_queued", bufEmpty, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("wd_reset_empty", bufEmpty, 1);
    chk("wd_reset_txData", txData, 0);
    txBusy = 1'b0;
    base = n_starts;
    ticks(20);
    chk("wd_no_start", n_starts - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
